// File: rtl/mac_sequencer_pkg.sv
// Shared accumulator package: sequencer state encoding and the default
// frame geometry used by the MAC accumulate path.
package mac_sequencer_pkg;

  // Default number of product terms per accumulation frame.
  localparam int K_DEF       = 9;
  // Default width of the valid delay vector (frame bit plus pipeline bits).
  localparam int DEPTH_DEF   = 12;
  // Default settle cycles between acc_rdy_i and a valid result.
  localparam int POST_DEF    = 2;
  // Default number of cycles allowed in DRAIN before the frame is dropped.
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_POSTW,
    ST_DONE,
    ST_CLEAR
  } state_t;

  // The frame bit is high for every state that holds an open frame.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LOAD) || (s == ST_DRAIN) || (s == ST_POSTW) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/mac_sequencer_vld_shift.sv
// Valid pipeline shift register: tracks which multiplier stages hold a live
// product. A synchronous clear empties the pipe in one cycle.
module vld_shift #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rstn,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  // Shift one new valid bit in per cycle; clear wins over shifting.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// MAC frame sequencer: accepts K operand pairs per frame, drives the valid
// delay vector of the accumulate datapath, waits for the accumulator, then
// hands the result over and clears the datapath before the next frame.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int POST    = POST_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 acc_rdy_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DEPTH-1:0]     vld_d_o,
  output logic [$clog2(K):0]   cnt_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CW   = $clog2(K) + 1;
  localparam int TMAX = (TIMEOUT > POST) ? TIMEOUT : POST;
  localparam int TW   = $clog2(TMAX) + 1;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tmr;
  logic             err;
  logic             cnt_full;
  logic             ready;
  logic             fire;
  logic             timeout_hit;
  logic             going_clear;
  logic [DEPTH-2:0] shift_q;

  // Handshake terms: accept only in LOAD and only until K terms are in.
  always_comb begin
    cnt_full    = (cnt == CW'(K));
    ready       = (state == ST_LOAD) && !cnt_full;
    fire        = in_valid_i && ready;
    going_clear = (next_state == ST_CLEAR);
  end

  // Next-state logic; abort outranks fire, acc_rdy_i and out_ready_i.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_i)                            next_state = ST_CLEAR;
        else if (fire && (cnt == CW'(K - 1)))   next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_i) begin
          next_state = ST_CLEAR;
        end else if (acc_rdy_i) begin
          next_state = ST_POSTW;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          next_state  = ST_CLEAR;
          timeout_hit = 1'b1;
        end
      end
      ST_POSTW: begin
        if (abort_i)                     next_state = ST_CLEAR;
        else if (tmr == TW'(POST - 1))   next_state = ST_DONE;
      end
      ST_DONE: begin
        if (abort_i || out_ready_i) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Term counter: zero for the whole CLEAR cycle, saturates at K.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (going_clear || (state == ST_CLEAR)) begin
      cnt <= '0;
    end else if (fire && !cnt_full) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shared DRAIN/POSTW cycle counter, restarted on every state change.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      tmr <= '0;
    end else if (next_state != state) begin
      tmr <= '0;
    end else if ((state == ST_DRAIN) || (state == ST_POSTW)) begin
      tmr <= tmr + TW'(1);
    end
  end

  // Sticky timeout flag, cleared by the start that opens the next frame.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if ((state == ST_IDLE) && start_i) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end

  vld_shift #(
    .W (DEPTH - 1)
  ) u_vld_shift (
    .clk_i (clk_i),
    .rstn  (rstn),
    .clr   (going_clear),
    .din   (fire),
    .q     (shift_q)
  );

  // Output mapping; every output derives from registered state only.
  always_comb begin
    vld_d_o     = {in_frame(state), shift_q};
    in_ready_o  = ready;
    out_valid_o = (state == ST_DONE);
    busy_o      = (state != ST_IDLE);
    cnt_o       = cnt;
    err_o       = err;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: each stimulus step pushes the outputs
// expected after the coming clock edge; a monitor pops and compares them.
module tb_mac_sequencer;

  localparam int DEPTH = 12;
  localparam int CW    = 5;

  typedef struct packed {
    int unsigned     cyc;
    logic [DEPTH-1:0] vld;
    logic [CW-1:0]   cnt;
    logic            rdy;
    logic            ov;
    logic            busy;
    logic            err;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rstn;
  logic             start_i, abort_i, in_valid_i, acc_rdy_i, out_ready_i;
  logic             in_ready_o, out_valid_o, busy_o, err_o;
  logic [DEPTH-1:0] vld_d_o;
  logic [CW-1:0]    cnt_o;

  exp_t             exp_q[$];
  string            tag_q[$];
  int unsigned      cycles = 0;
  int               total = 0;
  int               bad = 0;

  logic [DEPTH-2:0] hist;
  logic [CW-1:0]    e_cnt;
  logic             e_rdy, e_ov, e_busy, e_err, e_frame;

  mac_sequencer dut (
    .clk_i       (clk_i),
    .rstn        (rstn),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .acc_rdy_i   (acc_rdy_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .vld_d_o     (vld_d_o),
    .cnt_o       (cnt_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Edge counter used to time-stamp expectations.
  always @(posedge clk_i) cycles <= cycles + 1;

  task automatic setExp(input int c, input logic r, o, b, e, fr);
    e_cnt = CW'(c); e_rdy = r; e_ov = o; e_busy = b; e_err = e; e_frame = fr;
  endtask

  task automatic pushExp(input string tag);
    exp_t x;
    x.cyc = cycles + 1;
    x.vld = {e_frame, hist};
    x.cnt = e_cnt; x.rdy = e_rdy; x.ov = e_ov; x.busy = e_busy; x.err = e_err;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  // f: a term is expected to be accepted this cycle; clr: the pipe is expected empty after the edge.
  task automatic applyStimulus(input logic st, ab, iv, ar, orr, f, clr, input string tag);
    @(negedge clk_i);
    start_i = st; abort_i = ab; in_valid_i = iv; acc_rdy_i = ar; out_ready_i = orr;
    if (clr) hist = '0;
    else     hist = {hist[DEPTH-3:0], f};
    pushExp(tag);
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    logic [DEPTH+CW+3:0] act, req;
    act = {vld_d_o, cnt_o, in_ready_o, out_valid_o, busy_o, err_o};
    req = {e.vld, e.cnt, e.rdy, e.ov, e.busy, e.err};
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s @%0d: got vld=%h cnt=%0d rdy=%b ov=%b busy=%b err=%b, want vld=%h cnt=%0d rdy=%b ov=%b busy=%b err=%b",
               tag, cycles, vld_d_o, cnt_o, in_ready_o, out_valid_o, busy_o, err_o,
               e.vld, e.cnt, e.rdy, e.ov, e.busy, e.err);
    end
  endtask

  // Monitor: compare every expectation due after the latest rising edge.
  always @(negedge clk_i) begin
    while ((exp_q.size() > 0) && (exp_q[0].cyc == cycles)) begin
      checkOutput(exp_q.pop_front(), tag_q.pop_front());
    end
  end

  task automatic openAndFill(input int n, input string tag);
    setExp(0, 1, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "start");
    for (int i = 1; i <= n; i++) begin
      setExp(i, i < 9, 0, 1, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 1, 0, tag);
    end
  endtask

  initial begin
    rstn = 1'b0; hist = '0;
    start_i = 0; abort_i = 0; in_valid_i = 0; acc_rdy_i = 0; out_ready_i = 0;
    setExp(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "reset_a");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "reset_b");
    @(negedge clk_i); rstn = 1'b1;

    // Back-to-back frame with stray acc_rdy_i in LOAD and start_i in DRAIN/DONE.
    setExp(0, 1, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "b2b_start");
    for (int i = 1; i <= 9; i++) begin
      setExp(i, i < 9, 0, 1, 0, 1);
      applyStimulus(0, 0, 1, (i == 3), 0, 1, 0, "b2b_fire");
    end
    setExp(9, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(i == 1, 0, 1, 0, 0, 0, 0, "b2b_drain");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, "b2b_accrdy");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "b2b_postw");
    setExp(9, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "b2b_done_rise");
    for (int i = 0; i < 5; i++) applyStimulus(i == 2, 0, 0, 0, 0, 0, 0, "b2b_done_hold");
    setExp(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, "b2b_clear");
    setExp(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "b2b_idle");

    // Gapped input, then abort from DRAIN.
    openAndFill(4, "gap_fire");
    setExp(4, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "gap_hold");
    for (int i = 5; i <= 9; i++) begin
      setExp(i, i < 9, 0, 1, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 1, 0, "gap_fire2");
    end
    setExp(9, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "gap_drain");
    setExp(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, "gap_abort");
    setExp(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "gap_idle");

    // Timeout: 64 DRAIN cycles without acc_rdy_i, sticky err_o.
    openAndFill(9, "tmo_fire");
    setExp(9, 0, 0, 1, 0, 1);
    for (int j = 1; j <= 63; j++) applyStimulus(0, 0, 0, 0, 0, 0, 0, "tmo_drain");
    setExp(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "tmo_clear");
    setExp(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "tmo_idle");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, "idle_abort");
    applyStimulus(0, 0, 1, 1, 1, 0, 0, "idle_noise");

    // Next start clears err_o; abort together with a fire at cnt_o=5.
    setExp(0, 1, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "err_clear_start");
    for (int i = 1; i <= 5; i++) begin
      setExp(i, 1, 0, 1, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 1, 0, "abf_fire");
    end
    setExp(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 1, "abf_clear");
    setExp(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "abf_idle");

    // Reset in LOAD at cnt_o=3, then a clean full frame.
    openAndFill(3, "rst_fire");
    @(negedge clk_i); #1;
    rstn = 1'b0; in_valid_i = 0; hist = '0;
    setExp(0, 0, 0, 0, 0, 0);
    pushExp("rst_mid");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "rst_hold");
    @(negedge clk_i); rstn = 1'b1;
    openAndFill(9, "post_rst_fire");
    setExp(9, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, "post_rst_accrdy");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "post_rst_postw");
    setExp(9, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, "post_rst_done");
    setExp(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, "post_rst_clear");
    setExp(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "post_rst_idle");

    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
